uart_port_arbiter: RTL and testbench
====================================

# uart_port_arbiter

Automatic arbiter that drives the 2-bit port select of the UART selector, sharing the single host UART (tx2/rx2) among the four downstream UART ports (rx3..rx6 / tx3..tx6). It watches the four downstream RX lines for start bits and grants the host UART to one port at a time, round-robin. It holds each grant until the granted link has been idle for a programmable time, so frames are never cut mid-byte. A host override can force a fixed port.

## Interface
Parameters:
- CLKS_PER_BIT, default 434: clock cycles per UART bit; must be ≥ 16.
- IDLE_BITS, default 20: bit times of continuous idle, on both granted RX and host TX, required before releasing a grant.

Ports:
- clk  input  1  single system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_in  input  4  downstream RX lines, bit0=rx3 … bit3=rx6; idle high; asynchronous to clk.
- tx_host  input  1  host transmit line (tx2); idle high; asynchronous to clk.
- force_en  input  1  override enable, synchronous to clk.
- force_sel  input  2  port to select while force_en=1.
- sel  output  2  {s1,s0} to the selector; registered.
- grant_valid  output  1  1 while a port is granted (arbitrated or forced); registered.
- pending  output  4  latched requests not yet served; registered.

## Operation
- Synchronizers: rx_in[3:0] and tx_host each pass through 2 flops, then one delay flop for edge detection. All logic below uses the synchronized values.
- Request latch: a falling edge on synchronized rx[i] sets pending[i], except when port i is currently granted. pending[i] clears in the cycle port i is granted. Edges on an already-pending port have no further effect.
- States:
  - IDLE: grant_valid=0; sel holds the last granted value.
  - GRANT: grant_valid=1; sel fixed.
  - FORCED: grant_valid=1; sel=force_sel, updated every cycle.
- IDLE → GRANT: when any pending bit is set. The winner is the first set bit in search order last+1, last+2, last+3, last (mod 4). sel←winner and last←winner. The idle counter clears.
- GRANT: the idle counter increments each cycle in which synchronized rx[sel]=1 and synchronized tx_host=1. It clears to 0 on any cycle where either line is 0.
- GRANT → IDLE: when the counter reaches IDLE_BITS*CLKS_PER_BIT−1 and increments. The counter clears. A pending request is granted on the following cycle, not the same cycle.
- Counter width: clog2(IDLE_BITS*CLKS_PER_BIT+1). The counter saturates and never wraps.
- force_en=1 from any state → FORCED on the next edge. Requests keep latching in FORCED, including the forced port.
- force_en=0 in FORCED → IDLE. last←force_sel, and pending requests are then served normally.
- force_en has priority over every other transition in the same cycle.

## Timing
- Reset values: sel=2'b00, grant_valid=0, pending=4'b0000, last=3 (so port 0 has first priority), state=IDLE, counter=0. All synchronizer flops reset to 1 (idle).
- Request latency: rx_in falling (sampled at edge N) → pending[i]=1 after edge N+3.
- Grant latency: from IDLE, pending set after edge k → sel/grant_valid updated after edge k+1. Total rx_in fall → sel change is 4 clocks, well inside half a bit at CLKS_PER_BIT ≥ 16.
- Release: exactly IDLE_BITS*CLKS_PER_BIT consecutive idle cycles after the last low sample, then grant_valid falls on the next edge.
- Simultaneous edges on several ports in the same cycle: all pending bits set, and the round-robin order decides which port is served.
- Reset asserted mid-grant: all outputs return to reset values immediately, with no glitch sequencing required. After deassertion, pending is empty.
- force_sel may change while FORCED: sel follows with 1-clock latency.

## Test plan
Use CLKS_PER_BIT=16, IDLE_BITS=2 (32-cycle release):
- Reset then idle lines: sel=0, grant_valid=0, pending=0 for 100 cycles.
- Frame on rx_in[2] (0x55 at 16 clk/bit): pending[2] goes high 3 clocks after the fall, then sel=2 and grant_valid=1 one clock later. Grant is held during the frame. grant_valid drops exactly 32 cycles after the stop bit's synchronized rising edge. sel stays 2 afterwards.
- Port 1 starts a frame while port 3 is granted: pending=4'b0010 while port 3 is held. After port 3 releases, the next cycle gives sel=1 and pending=0.
- Simultaneous falls on ports 0 and 3 with last=3: port 0 is served first, then port 3. Repeat with last=0: port 3 is served first.
- Host tx_host low pulses every 20 cycles with the granted RX idle: the grant never releases. Stop the pulses and grant_valid falls 32 cycles after the last rise.
- Apply force_en=1, force_sel=2 mid-grant: sel=2 and grant_valid=1 next cycle. A port 0 frame sets pending[0]. Drop force_en: one IDLE cycle, then sel=0. Reset asserted during GRANT: sel=0 and grant_valid=0 immediately.

Source files
------------

// File: rtl/uart_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_port_arbiter
// Description : Shares one host UART among four downstream UART ports.
//               Start bits on the downstream RX lines are latched as
//               requests. Requests are served round-robin, and each grant is
//               held until both the granted RX line and the host TX line
//               have been idle for IDLE_BITS bit times. A host override can
//               force a fixed port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_port_arbiter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int IDLE_BITS    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rx_in,
  input  logic       tx_host,
  input  logic       force_en,
  input  logic [1:0] force_sel,
  output logic [1:0] sel,
  output logic       grant_valid,
  output logic [3:0] pending
);

  localparam int               IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int               CNT_W      = $clog2(IDLE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(IDLE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(IDLE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_FORCED = 2'd2
  } state_t;

  // Synchronizer chain, edge-detect delay stage and registered fall strobe
  logic [3:0] rx_meta_q, rx_meta_d;
  logic [3:0] rx_sync_q, rx_sync_d;
  logic [3:0] rx_dly_q,  rx_dly_d;
  logic [3:0] rx_fall_q, rx_fall_d;
  logic       tx_meta_q, tx_meta_d;
  logic       tx_sync_q, tx_sync_d;

  // Arbiter state
  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             grant_valid_q, grant_valid_d;
  logic [3:0]       pending_q, pending_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational helpers
  logic [3:0] granted_mask;
  logic       line_idle;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Next values for the input synchronizers; the fall strobe is registered
  // so the request latch sees a clean single-cycle pulse per start bit.
  always_comb begin
    rx_meta_d = rx_in;
    rx_sync_d = rx_meta_q;
    rx_dly_d  = rx_sync_q;
    rx_fall_d = rx_dly_q & ~rx_sync_q;
    tx_meta_d = tx_host;
    tx_sync_d = tx_meta_q;
  end

  // Request latch, round-robin winner search and grant state machine
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    grant_valid_d = grant_valid_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    granted_mask  = 4'b0000;
    win_found     = 1'b0;
    win_idx       = last_q;
    cand          = 2'd0;

    // Only an arbitrated grant masks its own port; forced ports still latch.
    if (state_q == ST_GRANT) begin
      granted_mask[sel_q] = 1'b1;
    end
    pending_d = pending_q | (rx_fall_q & ~granted_mask);

    // Search order last+1, last+2, last+3, last (2-bit wrap-around).
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && pending_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    line_idle = rx_sync_q[sel_q] & tx_sync_q;

    if (force_en) begin
      state_d       = ST_FORCED;
      sel_d         = force_sel;
      grant_valid_d = 1'b1;
      cnt_d         = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_d            = ST_GRANT;
            sel_d              = win_idx;
            last_d             = win_idx;
            grant_valid_d      = 1'b1;
            cnt_d              = '0;
            pending_d[win_idx] = 1'b0;
          end
        end
        ST_GRANT: begin
          if (line_idle) begin
            if (cnt_q == CNT_LAST) begin
              state_d       = ST_IDLE;
              grant_valid_d = 1'b0;
              cnt_d         = '0;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_FORCED: begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          last_d        = force_sel;
          cnt_d         = '0;
        end
        default: begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          cnt_d         = '0;
        end
      endcase
    end
  end

  // State register; synchronizers reset to the idle-high line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q     <= 4'b1111;
      rx_sync_q     <= 4'b1111;
      rx_dly_q      <= 4'b1111;
      rx_fall_q     <= 4'b0000;
      tx_meta_q     <= 1'b1;
      tx_sync_q     <= 1'b1;
      state_q       <= ST_IDLE;
      sel_q         <= 2'd0;
      grant_valid_q <= 1'b0;
      pending_q     <= 4'b0000;
      last_q        <= 2'd3;
      cnt_q         <= '0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rx_sync_q     <= rx_sync_d;
      rx_dly_q      <= rx_dly_d;
      rx_fall_q     <= rx_fall_d;
      tx_meta_q     <= tx_meta_d;
      tx_sync_q     <= tx_sync_d;
      state_q       <= state_d;
      sel_q         <= sel_d;
      grant_valid_q <= grant_valid_d;
      pending_q     <= pending_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
    end
  end

  assign sel         = sel_q;
  assign grant_valid = grant_valid_q;
  assign pending     = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_port_arbiter
// Description : Directed self-checking bench for uart_port_arbiter with
//               CLKS_PER_BIT=16 and IDLE_BITS=2 (32-cycle release).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_port_arbiter;

  localparam int CPB = 16;
  localparam int IB  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rx_in;
  logic       tx_host;
  logic       force_en;
  logic [1:0] force_sel;
  logic [1:0] sel;
  logic       grant_valid;
  logic [3:0] pending;

  int checks   = 0;
  int failures = 0;

  uart_port_arbiter #(
    .CLKS_PER_BIT(CPB),
    .IDLE_BITS   (IB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .tx_host    (tx_host),
    .force_en   (force_en),
    .force_sel  (force_sel),
    .sel        (sel),
    .grant_valid(grant_valid),
    .pending    (pending)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compares {sel, grant_valid, pending} as one 7-bit word
  task automatic expect_out(input string tag, input logic [1:0] s, input logic g, input logic [3:0] p);
    check_eq(tag, {25'd0, sel, grant_valid, pending}, {25'd0, s, g, p});
  endtask

  // Advance past the next rising edge; inputs set afterwards are sampled on the following edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Low pulse on one port long enough to be granted (fall -> grant is 5 ticks here)
  task automatic grant_port(input int p);
    rx_in[p] = 1'b0;
    ticks(5);
    check_eq("grant_port_sel", {31'd0, grant_valid}, 32'd1);
    check_eq("grant_port_idx", {30'd0, sel}, p);
    rx_in[p] = 1'b1;
  endtask

  // Bounded wait for the grant to drop; stops right after the release edge
  task automatic wait_release(input string tag);
    for (int i = 0; i < 120; i++) begin
      if (!grant_valid) break;
      tick();
    end
    check_eq(tag, {31'd0, grant_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] data;
    data      = 8'h55;
    reset     = 1'b1;
    rx_in     = 4'hF;
    tx_host   = 1'b1;
    force_en  = 1'b0;
    force_sel = 2'd0;
    ticks(2);
    expect_out("reset_state", 2'd0, 1'b0, 4'b0000);
    reset = 1'b0;

    // Quiet lines: nothing may happen
    for (int i = 0; i < 100; i++) begin
      tick();
      expect_out("idle_quiet", 2'd0, 1'b0, 4'b0000);
    end

    // Frame 0x55 on port 2 with latency checks
    rx_in[2] = 1'b0;
    ticks(3);
    expect_out("req_lat_early", 2'd0, 1'b0, 4'b0000);
    tick();
    expect_out("req_lat", 2'd0, 1'b0, 4'b0100);
    tick();
    expect_out("grant_lat", 2'd2, 1'b1, 4'b0000);
    ticks(CPB - 5);
    for (int b = 0; b < 8; b++) begin
      rx_in[2] = data[b];
      ticks(CPB);
      check_eq("hold_frame", {31'd0, grant_valid}, 32'd1);
    end
    rx_in[2] = 1'b1;
    ticks(33);
    expect_out("pre_release_p2", 2'd2, 1'b1, 4'b0000);
    tick();
    expect_out("release_p2", 2'd2, 1'b0, 4'b0000);

    // Port 1 requests while port 3 is granted
    rx_in[3] = 1'b0;
    ticks(5);
    expect_out("grant_p3", 2'd3, 1'b1, 4'b0000);
    rx_in[1] = 1'b0;
    ticks(4);
    expect_out("p1_pending", 2'd3, 1'b1, 4'b0010);
    rx_in[1] = 1'b1;
    ticks(10);
    rx_in[3] = 1'b1;
    ticks(33);
    expect_out("p3_hold", 2'd3, 1'b1, 4'b0010);
    tick();
    expect_out("p3_release", 2'd3, 1'b0, 4'b0010);
    tick();
    expect_out("p1_grant", 2'd1, 1'b1, 4'b0000);
    wait_release("p1_release");

    // Simultaneous falls on ports 0 and 3 with last=3
    grant_port(3);
    wait_release("p3_solo_release");
    rx_in = 4'b0110;
    ticks(4);
    expect_out("sim_pend", 2'd3, 1'b0, 4'b1001);
    tick();
    expect_out("sim_first0", 2'd0, 1'b1, 4'b1000);
    rx_in = 4'hF;
    wait_release("sim_rel0");
    expect_out("sim_gap", 2'd0, 1'b0, 4'b1000);
    tick();
    expect_out("sim_second3", 2'd3, 1'b1, 4'b0000);
    wait_release("sim_rel3");

    // Same collision with last=0: port 3 goes first
    grant_port(0);
    wait_release("p0_solo_release");
    rx_in = 4'b0110;
    ticks(5);
    expect_out("rr_first3", 2'd3, 1'b1, 4'b0001);
    rx_in = 4'hF;
    wait_release("rr_rel3");
    tick();
    expect_out("rr_second0", 2'd0, 1'b1, 4'b0000);
    wait_release("rr_rel0");

    // Host TX activity keeps the grant alive
    grant_port(2);
    for (int n = 0; n < 4; n++) begin
      tx_host = 1'b0;
      ticks(2);
      tx_host = 1'b1;
      ticks(18);
      check_eq("tx_hold", {31'd0, grant_valid}, 32'd1);
    end
    tx_host = 1'b0;
    ticks(2);
    tx_host = 1'b1;
    ticks(33);
    expect_out("tx_pre_release", 2'd2, 1'b1, 4'b0000);
    tick();
    expect_out("tx_release", 2'd2, 1'b0, 4'b0000);

    // Override mid-grant
    grant_port(1);
    force_en  = 1'b1;
    force_sel = 2'd2;
    tick();
    expect_out("force_enter", 2'd2, 1'b1, 4'b0000);
    force_sel = 2'd3;
    tick();
    expect_out("force_follow", 2'd3, 1'b1, 4'b0000);
    force_sel = 2'd2;
    tick();
    expect_out("force_back", 2'd2, 1'b1, 4'b0000);
    rx_in[0] = 1'b0;
    ticks(4);
    expect_out("force_pend", 2'd2, 1'b1, 4'b0001);
    rx_in[0] = 1'b1;
    rx_in[2] = 1'b0;
    ticks(4);
    expect_out("force_pend_self", 2'd2, 1'b1, 4'b0101);
    rx_in[2] = 1'b1;
    force_en = 1'b0;
    tick();
    expect_out("force_exit_idle", 2'd2, 1'b0, 4'b0101);
    tick();
    expect_out("force_serve", 2'd0, 1'b1, 4'b0100);

    // Asynchronous reset in the middle of a grant
    tick();
    #3;
    reset = 1'b1;
    #1;
    expect_out("async_reset", 2'd0, 1'b0, 4'b0000);
    tick();
    reset = 1'b0;
    ticks(10);
    expect_out("post_reset", 2'd0, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
